fp4_fft_stage_ctrl: RTL

//  Sequencer for the 32-point radix-2 in-place FFT built around fp4_fft_memory (ping-pong, dual port).
//  Per stage: issues butterfly operand addresses, the twiddle index and operand-valid; replays the

---
 rtl/fp4_fft_stage_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fp4_fft_stage_ctrl.sv
// Stage sequencer for the in-place radix-2 FFT: issues butterfly read addresses and twiddle
// indices, replays them as write strobes WR_LAT cycles later, and flips the ping-pong bank per stage.
module fp4_fft_stage_ctrl #(
    parameter int N_LOG2 = 5,
    parameter int WR_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [2:0]        stage,
    output logic              bank_sel,
    output logic              result_bank,
    output logic [N_LOG2-1:0] rd_addr_0,
    output logic [N_LOG2-1:0] rd_addr_1,
    output logic              op_valid,
    output logic [N_LOG2-2:0] tw_addr,
    output logic              wr_en_0,
    output logic [N_LOG2-1:0] wr_addr_0,
    output logic              wr_en_1,
    output logic [N_LOG2-1:0] wr_addr_1
);

    localparam logic [N_LOG2-1:0] ONE        = {{(N_LOG2-1){1'b0}}, 1'b1};
    localparam logic [N_LOG2-1:0] HALF       = ONE << (N_LOG2-1);
    localparam logic [2:0]        LAST_STAGE = 3'(N_LOG2-1);
    localparam int                CW         = $clog2(WR_LAT+1);
    localparam logic [CW-1:0]     LAST_CNT   = CW'(WR_LAT-1);
    localparam int                DW         = 2*N_LOG2+1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [N_LOG2-1:0] j;
    logic [CW-1:0]     cnt;
    logic [DW-1:0]     dl [WR_LAT];

    // Top operand: insert a zero at bit s of the butterfly index.
    function automatic logic [N_LOG2-1:0] addr_a(input logic [2:0] s, input logic [N_LOG2-1:0] jj);
        logic [N_LOG2-1:0] mask;
        mask = (ONE << s) - ONE;
        return ((jj >> s) << (s + 3'd1)) | (jj & mask);
    endfunction

    function automatic logic [N_LOG2-1:0] addr_b(input logic [2:0] s, input logic [N_LOG2-1:0] jj);
        return addr_a(s, jj) + (ONE << s);
    endfunction

    function automatic logic [N_LOG2-2:0] tw_of(input logic [2:0] s, input logic [N_LOG2-1:0] jj);
        logic [N_LOG2-1:0] mask;
        logic [N_LOG2-1:0] t;
        mask = (ONE << s) - ONE;
        t    = (jj & mask) << (LAST_STAGE - s);
        return t[N_LOG2-2:0];
    endfunction

    assign wr_en_0   = dl[WR_LAT-1][DW-1];
    assign wr_en_1   = dl[WR_LAT-1][DW-1];
    assign wr_addr_0 = dl[WR_LAT-1][DW-2:N_LOG2];
    assign wr_addr_1 = dl[WR_LAT-1][N_LOG2-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            j           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            stage       <= '0;
            bank_sel    <= 1'b0;
            result_bank <= 1'b0;
            rd_addr_0   <= '0;
            rd_addr_1   <= '0;
            op_valid    <= 1'b0;
            tw_addr     <= '0;
            for (int i = 0; i < WR_LAT; i++) dl[i] <= '0;
        end else begin
            // The write delay line replays exactly what was issued, so it just trails the read outputs.
            dl[0] <= {op_valid, rd_addr_0, rd_addr_1};
            for (int i = 1; i < WR_LAT; i++) dl[i] <= dl[i-1];

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_ISSUE;
                        busy        <= 1'b1;
                        stage       <= '0;
                        bank_sel    <= 1'b0;
                        result_bank <= 1'b0;
                        op_valid    <= 1'b1;
                        rd_addr_0   <= addr_a(3'd0, '0);
                        rd_addr_1   <= addr_b(3'd0, '0);
                        tw_addr     <= tw_of(3'd0, '0);
                        j           <= ONE;
                    end
                end
                S_ISSUE: begin
                    if (j == HALF) begin
                        state     <= S_DRAIN;
                        op_valid  <= 1'b0;
                        rd_addr_0 <= '0;
                        rd_addr_1 <= '0;
                        tw_addr   <= '0;
                        cnt       <= '0;
                    end else begin
                        op_valid  <= 1'b1;
                        rd_addr_0 <= addr_a(stage, j);
                        rd_addr_1 <= addr_b(stage, j);
                        tw_addr   <= tw_of(stage, j);
                        j         <= j + ONE;
                    end
                end
                // The stage's last write lands in the final drain cycle, so the bank flips only after it.
                S_DRAIN: begin
                    if (cnt == LAST_CNT) begin
                        if (stage == LAST_STAGE) begin
                            state       <= S_DONE;
                            done        <= 1'b1;
                            result_bank <= ~bank_sel;
                        end else begin
                            state     <= S_ISSUE;
                            stage     <= stage + 3'd1;
                            bank_sel  <= ~bank_sel;
                            op_valid  <= 1'b1;
                            rd_addr_0 <= addr_a(stage + 3'd1, '0);
                            rd_addr_1 <= addr_b(stage + 3'd1, '0);
                            tw_addr   <= tw_of(stage + 3'd1, '0);
                            j         <= ONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
